// File: rtl/l3_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : l3_cfg_sequencer_if
//  Description : Command handshake, status and per-codec L3 line bundle for
//                the L3 configuration sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface l3_cfg_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_codec;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       busy;
  logic       done;
  logic [3:0] ad_l3md;
  logic [3:0] ad_l3clk;
  logic [3:0] ad_l3data;

  // Command source / line observer side
  modport master (
    output cmd_valid, cmd_codec, cmd_addr, cmd_data,
    input  cmd_ready, busy, done, ad_l3md, ad_l3clk, ad_l3data
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_codec, cmd_addr, cmd_data,
    output cmd_ready, busy, done, ad_l3md, ad_l3clk, ad_l3data
  );
endinterface
`default_nettype wire

// File: rtl/l3_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : l3_cfg_sequencer
//  Description : Serialises one L3 address byte and one L3 data byte to one of
//                four codecs. Bits go out LSB first, one bit per L3CLK period
//                (HALF_DIV low then HALF_DIV high), with an L3MODE-high gap of
//                GAP_CYC cycles after each byte. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module l3_cfg_sequencer #(
  parameter int HALF_DIV = 12,
  parameter int GAP_CYC  = 24
) (
  input  logic                clk,
  input  logic                Rst,
  l3_cfg_sequencer_if.slave   bus
);

  localparam int HC_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int GC_W = (GAP_CYC  > 1) ? $clog2(GAP_CYC)  : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_DIV - 1);
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_GAP1 = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP2 = 3'd4
  } state_t;

  state_t          r_state;
  logic [HC_W-1:0] r_half_cnt;
  logic [GC_W-1:0] r_gap_cnt;
  logic [2:0]      r_bit_cnt;
  logic            r_sclk;      // level of L3CLK on the selected codec
  logic [1:0]      r_codec;
  logic [6:0]      r_shift;     // remaining bits of the byte being sent
  logic [7:0]      r_data;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic [3:0]      r_md;
  logic [3:0]      r_clk;
  logic [3:0]      r_dat;

  logic            w_accept;
  logic [3:0]      w_sel_in;    // one-hot of the incoming codec index
  logic [3:0]      w_sel;       // one-hot of the captured codec index

  assign w_accept = bus.cmd_valid & r_ready;
  assign w_sel_in = 4'b0001 << bus.cmd_codec;
  assign w_sel    = 4'b0001 << r_codec;

  assign bus.cmd_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.ad_l3md   = r_md;
  assign bus.ad_l3clk  = r_clk;
  assign bus.ad_l3data = r_dat;

  // Transfer FSM: state, counters and every output line updated together
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state    <= ST_IDLE;
      r_half_cnt <= '0;
      r_gap_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_sclk     <= 1'b1;
      r_codec    <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_md       <= 4'hF;
      r_clk      <= 4'hF;
      r_dat      <= 4'hF;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // First L3CLK fall and address bit 0 appear right after accept
            r_state    <= ST_ADDR;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_codec    <= bus.cmd_codec;
            r_shift    <= bus.cmd_addr[7:1];
            r_data     <= bus.cmd_data;
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_md       <= ~w_sel_in;
            r_clk      <= ~w_sel_in;
            r_dat      <= bus.cmd_addr[0] ? 4'hF : ~w_sel_in;
          end else begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end

        ST_ADDR, ST_DATA: begin
          if (r_half_cnt != HC_LAST) begin
            r_half_cnt <= r_half_cnt + 1'b1;
          end else begin
            r_half_cnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              r_clk  <= 4'hF;
            end else begin
              // 3-bit counter wraps 7->0 exactly at the byte end
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_state   <= (r_state == ST_ADDR) ? ST_GAP1 : ST_GAP2;
                r_gap_cnt <= '0;
                r_md      <= 4'hF;
                r_dat     <= 4'hF;
              end else begin
                r_sclk  <= 1'b0;
                r_clk   <= ~w_sel;
                r_dat   <= r_shift[0] ? 4'hF : ~w_sel;
                r_shift <= {1'b0, r_shift[6:1]};
              end
            end
          end
        end

        ST_GAP1, ST_GAP2: begin
          if (r_gap_cnt != GC_LAST) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end else if (r_state == ST_GAP1) begin
            // Data byte keeps L3MODE high; start with a fall and bit 0
            r_state    <= ST_DATA;
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_clk      <= ~w_sel;
            r_dat      <= r_data[0] ? 4'hF : ~w_sel;
            r_shift    <= r_data[7:1];
          end else begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_md    <= 4'hF;
          r_clk   <= 4'hF;
          r_dat   <= 4'hF;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l3_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l3_cfg_sequencer
//  Description : Directed self-checking bench for l3_cfg_sequencer. One DUT
//                with default timing, one with HALF_DIV=2 / GAP_CYC=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l3_cfg_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  l3_cfg_sequencer_if bus1();
  l3_cfg_sequencer_if bus2();

  l3_cfg_sequencer dut1 (.clk(clk), .Rst(rst), .bus(bus1));
  l3_cfg_sequencer #(.HALF_DIV(2), .GAP_CYC(1)) dut2 (.clk(clk), .Rst(rst), .bus(bus2));

  // {done, cmd_ready, busy, md[3:0], clk[3:0], data[3:0]}
  logic [14:0] obs1;
  logic [14:0] obs2;
  assign obs1 = {bus1.done, bus1.cmd_ready, bus1.busy, bus1.ad_l3md, bus1.ad_l3clk, bus1.ad_l3data};
  assign obs2 = {bus2.done, bus2.cmd_ready, bus2.busy, bus2.ad_l3md, bus2.ad_l3clk, bus2.ad_l3data};

  localparam logic [14:0] IDLE_VEC  = 15'b010_1111_1111_1111;
  localparam logic [14:0] RESET_VEC = 15'b000_1111_1111_1111;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference waveform: sample n is taken after the n-th edge following accept
  function automatic logic [14:0] exp_vec(input int n, input int h, input int g,
                                          input logic [1:0] codec,
                                          input logic [7:0] addr, input logic [7:0] data);
    int t;
    int m;
    logic [7:0] byt;
    logic md, ck, dt, dn, rdy, bsy;
    logic [3:0] vmd, vck, vdt;
    t = 32*h + 2*g;
    md = 1'b1; ck = 1'b1; dt = 1'b1; dn = 1'b0; rdy = 1'b0; bsy = 1'b1;
    if (n >= t) begin
      bsy = 1'b0; rdy = 1'b1; dn = (n == t);
    end else if (n < 16*h || (n >= 16*h + g && n < 32*h + g)) begin
      if (n < 16*h) begin
        m = n; byt = addr; md = 1'b0;
      end else begin
        m = n - 16*h - g; byt = data; md = 1'b1;
      end
      ck = ((m % (2*h)) >= h);
      dt = byt[m / (2*h)];
    end
    vmd = 4'hF; vck = 4'hF; vdt = 4'hF;
    vmd[codec] = md; vck[codec] = ck; vdt[codec] = dt;
    return {dn, rdy, bsy, vmd, vck, vdt};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs1 !== RESET_VEC) begin
      n_err++; $display("FAIL reset_dut1 got=%h exp=%h", obs1, RESET_VEC);
    end
    n_cmp++;
    if (obs2 !== RESET_VEC) begin
      n_err++; $display("FAIL reset_dut2 got=%h exp=%h", obs2, RESET_VEC);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs1 !== IDLE_VEC) begin
      n_err++; $display("FAIL reset_release_dut1 got=%h exp=%h", obs1, IDLE_VEC);
    end
    n_cmp++;
    if (obs2 !== IDLE_VEC) begin
      n_err++; $display("FAIL reset_release_dut2 got=%h exp=%h", obs2, IDLE_VEC);
    end
  endtask

  task automatic test_single_write();
    logic [14:0] e;
    int t;
    int falls;
    logic prev;
    t = 32*12 + 2*24;
    falls = 0;
    @(negedge clk);
    bus1.cmd_valid = 1'b1; bus1.cmd_codec = 2'd2; bus1.cmd_addr = 8'h14; bus1.cmd_data = 8'hC1;
    @(posedge clk);
    prev = 1'b1;
    for (int n = 0; n <= t + 1; n++) begin
      @(negedge clk);
      e = exp_vec(n, 12, 24, 2'd2, 8'h14, 8'hC1);
      n_cmp++;
      if (obs1 !== e) begin
        n_err++; $display("FAIL single_write n=%0d got=%h exp=%h", n, obs1, e);
      end
      if (prev && !bus1.ad_l3clk[2]) falls++;
      prev = bus1.ad_l3clk[2];
      if (n == 0) begin
        // Later input changes must not affect the frame
        bus1.cmd_valid = 1'b0; bus1.cmd_codec = 2'd0; bus1.cmd_addr = 8'hFF; bus1.cmd_data = 8'h00;
      end
    end
    n_cmp++;
    if (falls !== 16) begin
      n_err++; $display("FAIL single_write_falls got=%0d exp=16", falls);
    end
  endtask

  task automatic test_busy_holdoff();
    logic [14:0] e;
    int t;
    int dones;
    t = 32*12 + 2*24;
    dones = 0;
    @(negedge clk);
    bus1.cmd_valid = 1'b1; bus1.cmd_codec = 2'd1; bus1.cmd_addr = 8'hA7; bus1.cmd_data = 8'h3C;
    @(posedge clk);
    for (int n = 0; n <= t + 20; n++) begin
      @(negedge clk);
      e = exp_vec(n, 12, 24, 2'd1, 8'hA7, 8'h3C);
      n_cmp++;
      if (obs1 !== e) begin
        n_err++; $display("FAIL busy_holdoff n=%0d got=%h exp=%h", n, obs1, e);
      end
      if (bus1.done) dones++;
      if (n == 0) bus1.cmd_valid = 1'b0;
      if (n == 50) begin
        bus1.cmd_valid = 1'b1; bus1.cmd_codec = 2'd3; bus1.cmd_data = 8'h00;
      end
      if (n == 53) bus1.cmd_valid = 1'b0;
    end
    n_cmp++;
    if (dones !== 1) begin
      n_err++; $display("FAIL busy_holdoff_dones got=%0d exp=1", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] e;
    int t;
    t = 32*12 + 2*24;
    @(negedge clk);
    bus1.cmd_valid = 1'b1; bus1.cmd_codec = 2'd0; bus1.cmd_addr = 8'h55; bus1.cmd_data = 8'h81;
    @(posedge clk);
    for (int n = 0; n <= t; n++) begin
      @(negedge clk);
      e = exp_vec(n, 12, 24, 2'd0, 8'h55, 8'h81);
      n_cmp++;
      if (obs1 !== e) begin
        n_err++; $display("FAIL b2b_first n=%0d got=%h exp=%h", n, obs1, e);
      end
      if (n == 0) begin
        bus1.cmd_codec = 2'd3; bus1.cmd_addr = 8'hE2; bus1.cmd_data = 8'h4B;
      end
    end
    for (int n = 0; n <= t + 1; n++) begin
      @(negedge clk);
      e = exp_vec(n, 12, 24, 2'd3, 8'hE2, 8'h4B);
      n_cmp++;
      if (obs1 !== e) begin
        n_err++; $display("FAIL b2b_second n=%0d got=%h exp=%h", n, obs1, e);
      end
      if (n == 0) bus1.cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset_abort();
    logic [14:0] e;
    int dones;
    logic [11:0] lines_and;
    dones = 0;
    lines_and = 12'hFFF;
    @(negedge clk);
    bus1.cmd_valid = 1'b1; bus1.cmd_codec = 2'd1; bus1.cmd_addr = 8'h00; bus1.cmd_data = 8'h00;
    @(posedge clk);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      e = exp_vec(n, 12, 24, 2'd1, 8'h00, 8'h00);
      if (n == 0 || n == 99) begin
        n_cmp++;
        if (obs1 !== e) begin
          n_err++; $display("FAIL abort_pre n=%0d got=%h exp=%h", n, obs1, e);
        end
      end
      if (n == 0) bus1.cmd_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs1 !== RESET_VEC) begin
      n_err++; $display("FAIL abort_reset got=%h exp=%h", obs1, RESET_VEC);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs1 !== IDLE_VEC) begin
      n_err++; $display("FAIL abort_ready got=%h exp=%h", obs1, IDLE_VEC);
    end
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (bus1.done) dones++;
      lines_and = lines_and & {bus1.ad_l3md, bus1.ad_l3clk, bus1.ad_l3data};
    end
    n_cmp++;
    if (dones !== 0) begin
      n_err++; $display("FAIL abort_no_done got=%0d exp=0", dones);
    end
    n_cmp++;
    if (lines_and !== 12'hFFF) begin
      n_err++; $display("FAIL abort_lines_high got=%h exp=fff", lines_and);
    end
  endtask

  task automatic test_fast_timing();
    logic [14:0] e;
    int t;
    t = 32*2 + 2*1;
    @(negedge clk);
    bus2.cmd_valid = 1'b1; bus2.cmd_codec = 2'd1; bus2.cmd_addr = 8'h96; bus2.cmd_data = 8'hFF;
    @(posedge clk);
    for (int n = 0; n <= t + 1; n++) begin
      @(negedge clk);
      e = exp_vec(n, 2, 1, 2'd1, 8'h96, 8'hFF);
      n_cmp++;
      if (obs2 !== e) begin
        n_err++; $display("FAIL fast_timing n=%0d got=%h exp=%h", n, obs2, e);
      end
      if (n == 0) bus2.cmd_valid = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus1.cmd_valid = 1'b0; bus1.cmd_codec = 2'd0; bus1.cmd_addr = 8'h00; bus1.cmd_data = 8'h00;
    bus2.cmd_valid = 1'b0; bus2.cmd_codec = 2'd0; bus2.cmd_addr = 8'h00; bus2.cmd_data = 8'h00;
    test_reset();
    test_single_write();
    test_busy_holdoff();
    test_back_to_back();
    test_reset_abort();
    test_fast_timing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
